// File: rtl/bcd_counter_seconds.sv
// Seconds stage: prescales the clock to a 1 Hz tick and counts 00..59 in two BCD digits.
// Optional preset path is built when BCD_SEC_LOAD_EN is defined.
module bcd_counter_seconds #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] bcd,
    output logic [3:0] bcd_10s,
    output logic       tick_1hz,
    output logic       min_tick
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] r_presc;
    logic [3:0]    r_units;
    logic [3:0]    r_tens;
    logic          r_tick;
    logic          r_min;

    logic          w_sec_tick;
    logic          w_digits_bad;
    logic [3:0]    w_units_nxt;
    logic [3:0]    w_tens_nxt;
    logic          w_wrap;

    assign w_sec_tick   = run && (r_presc == LAST);
    assign w_digits_bad = (r_units > 4'd9) || (r_tens > 4'd5);

`ifdef BCD_SEC_LOAD_EN
    logic w_load_ok;
    assign w_load_ok = load
                    && (load_val[3:0] <= 4'd9)
                    && (load_val[7:4] <= 4'd5);
`else
    logic w_unused;
    assign w_unused = ^{load, load_val};
`endif

    // Illegal encodings recover to 00 silently; only a genuine 59 wraps with min_tick.
    always_comb begin
        w_units_nxt = r_units;
        w_tens_nxt  = r_tens;
        w_wrap      = 1'b0;
        if (w_digits_bad) begin
            w_units_nxt = 4'd0;
            w_tens_nxt  = 4'd0;
        end else if (r_units != 4'd9) begin
            w_units_nxt = r_units + 4'd1;
        end else if (r_tens != 4'd5) begin
            w_units_nxt = 4'd0;
            w_tens_nxt  = r_tens + 4'd1;
        end else begin
            w_units_nxt = 4'd0;
            w_tens_nxt  = 4'd0;
            w_wrap      = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_presc <= '0;
            r_units <= 4'd0;
            r_tens  <= 4'd0;
            r_tick  <= 1'b0;
            r_min   <= 1'b0;
`ifdef BCD_SEC_LOAD_EN
        end else if (w_load_ok) begin
            r_presc <= '0;
            r_units <= load_val[3:0];
            r_tens  <= load_val[7:4];
            r_tick  <= 1'b0;
            r_min   <= 1'b0;
`endif
        end else begin
            r_tick <= w_sec_tick;
            r_min  <= w_sec_tick && w_wrap;
            if (run) begin
                r_presc <= w_sec_tick ? '0 : r_presc + 1'b1;
            end
            if (w_sec_tick) begin
                r_units <= w_units_nxt;
                r_tens  <= w_tens_nxt;
            end
        end
    end

    assign bcd      = r_units;
    assign bcd_10s  = r_tens;
    assign tick_1hz = r_tick;
    assign min_tick = r_min;

endmodule

// File: tb/tb_bcd_counter_seconds.sv
// Directed and randomized checks of bcd_counter_seconds against a
// seconds-as-integer reference model.
module tb_bcd_counter_seconds;

    localparam int TPS = 4;

    logic       clock;
    logic       reset;
    logic       run;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
    logic [3:0] bcd;
    logic [3:0] bcd_10s;
    logic       tick_1hz;
    logic       min_tick;

    int n_vec;
    int n_err;

    // reference model: prescaler count and elapsed seconds within the minute
    int m_pre;
    int m_sec;
    bit m_tick;
    bit m_min;
    int m_wraps;

    int  obs_min;
    bit  prev_zero;

    bcd_counter_seconds #(.TICKS_PER_SEC(TPS)) dut (
        .clock    (clock),
        .reset    (reset),
        .run      (run),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .bcd      (bcd),
        .bcd_10s  (bcd_10s),
        .tick_1hz (tick_1hz),
        .min_tick (min_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit rs, input bit cl, input bit rn,
                         input bit ld, input logic [7:0] lv);
        bit ld_ok;
        ld_ok = 1'b0;
`ifdef BCD_SEC_LOAD_EN
        ld_ok = ld && (lv[3:0] <= 9) && (lv[7:4] <= 5);
`endif
        if (rs || cl) begin
            m_pre  = 0;
            m_sec  = 0;
            m_tick = 0;
            m_min  = 0;
        end else if (ld_ok) begin
            m_pre  = 0;
            m_sec  = int'(lv[7:4]) * 10 + int'(lv[3:0]);
            m_tick = 0;
            m_min  = 0;
        end else begin
            m_tick = 0;
            m_min  = 0;
            if (rn) begin
                if (m_pre == TPS - 1) begin
                    m_pre  = 0;
                    m_tick = 1;
                    m_sec  = (m_sec + 1) % 60;
                    m_min  = (m_sec == 0);
                    if (m_min) m_wraps++;
                end else begin
                    m_pre++;
                end
            end
        end
    endtask

    task automatic step(input bit rs, input bit cl, input bit rn,
                        input bit ld, input logic [7:0] lv);
        reset    = rs;
        clear    = cl;
        run      = rn;
        load     = ld;
        load_val = lv;
        @(posedge clock);
        #1;
        model(rs, cl, rn, ld, lv);
        chk("bcd", int'(bcd), m_sec % 10);
        chk("bcd_10s", int'(bcd_10s), m_sec / 10);
        chk("tick_1hz", int'(tick_1hz), int'(m_tick));
        chk("min_tick", int'(min_tick), int'(m_min));
        if (bcd_10s == 4'd0 && !prev_zero) obs_min++;
        prev_zero = (bcd_10s == 4'd0);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_pre = 0; m_sec = 0; m_tick = 0; m_min = 0; m_wraps = 0;
        obs_min = 0; prev_zero = 1'b1;
        reset = 1'b1; clear = 1'b0; run = 1'b0; load = 1'b0; load_val = 8'h00;

        // reset for 3 cycles, then ticks at cycles 4, 8, 12
        repeat (3) step(1, 0, 0, 0, 8'h00);
        obs_min = 0;
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 1, 0, 8'h00);
            if (i % 4 == 0) chk("tick_at_cycle", int'(tick_1hz), 1);
        end
        chk("secs_after_3", int'({bcd_10s, bcd}), 'h03);

        // full minute: 09 -> 10 at tick 10, wrap at tick 60
        for (int i = 13; i <= 60 * TPS; i++) begin
            step(0, 0, 1, 0, 8'h00);
            if (i == 10 * TPS) chk("tick10", int'({bcd_10s, bcd}), 'h10);
        end
        chk("wrap_tick", int'(tick_1hz), 1);
        chk("wrap_min", int'(min_tick), 1);
        chk("min_count", obs_min, 1);
        chk("model_wraps", obs_min, m_wraps);

        // pause with prescaler at 2
        repeat (2) step(0, 0, 1, 0, 8'h00);
        repeat (10) step(0, 0, 0, 0, 8'h00);
        chk("paused_digits", int'({bcd_10s, bcd}), 'h00);
        step(0, 0, 1, 0, 8'h00);
        chk("resume1", int'(tick_1hz), 0);
        step(0, 0, 1, 0, 8'h00);
        chk("resume2", int'(tick_1hz), 1);

        // clear coincident with the 59 -> 00 tick
        for (int k = 0; k < 400 && !(m_sec == 59 && m_pre == TPS - 1); k++)
            step(0, 0, 1, 0, 8'h00);
        chk("seek59", int'({bcd_10s, bcd}), 'h59);
        step(0, 1, 1, 0, 8'h00);
        chk("clr_tick", int'(tick_1hz), 0);
        chk("clr_min", int'(min_tick), 0);
        repeat (TPS) step(0, 0, 1, 0, 8'h00);
        chk("clr_restart", int'(tick_1hz), 1);

        // reset at 37 mid-prescale
        for (int k = 0; k < 400 && !(m_sec == 37 && m_pre == 1); k++)
            step(0, 0, 1, 0, 8'h00);
        chk("seek37", int'({bcd_10s, bcd}), 'h37);
        step(1, 0, 1, 0, 8'h00);
        chk("rst37", int'({bcd_10s, bcd}), 'h00);
        repeat (TPS) step(0, 0, 1, 0, 8'h00);
        chk("rst_resume", int'({bcd_10s, bcd}), 'h01);

        // preset 58, two ticks to wrap; then an illegal preset
        step(0, 0, 0, 1, 8'h58);
`ifdef BCD_SEC_LOAD_EN
        chk("load58", int'({bcd_10s, bcd}), 'h58);
`else
        chk("load_ignored", int'({bcd_10s, bcd}), 'h01);
`endif
        repeat (2 * TPS) step(0, 0, 1, 0, 8'h00);
        step(0, 0, 1, 1, 8'h6A);
        step(0, 0, 0, 1, 8'h6A);

        // randomized mix of run, clear, reset and load
        for (int i = 0; i < 2000; i++) begin
            logic [7:0] lv;
            lv = 8'($urandom);
            if ($urandom_range(0, 1) == 0)
                lv = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 149) == 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 59) == 0,
                 lv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_counter_seconds.md
Name: bcd_counter_seconds

Overview:
Seconds stage of the clock chain, directly upstream of the BCD minute counter. Divides the system clock down to a 1 Hz tick and counts seconds 00..59 as two registered BCD digits. bcd_10s feeds the minute counter. That counter advances on the rising edge of (bcd_10s == 0), i.e. on the 59->00 wrap, so bcd_10s must be glitch-free and must change only on the wrap.

Parameters:
TICKS_PER_SEC, 50000000, clock cycles per second tick; legal range >= 2; prescaler width = clog2(TICKS_PER_SEC).

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high; zeroes all state
run  input  1  1 = prescaler counts; 0 = prescaler and digits hold
clear  input  1  synchronous clear of digits and prescaler
load  input  1  preset strobe (optional feature only)
load_val  input  8  preset value, [7:4] tens BCD, [3:0] units BCD (optional feature only)
bcd  output  4  units-of-seconds BCD digit, 0..9
bcd_10s  output  4  tens-of-seconds BCD digit, 0..5
tick_1hz  output  1  one-cycle pulse on each second tick
min_tick  output  1  one-cycle pulse on the 59->00 wrap

Behaviour:
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset (highest priority): prescaler = 0, bcd = 0, bcd_10s = 0, tick_1hz = 0, min_tick = 0. Reset takes effect on the next edge, including mid-count.
- Priority: reset > clear > load > count.
- clear=1: prescaler = 0, bcd = 0, bcd_10s = 0, tick_1hz = 0, min_tick = 0. Applies whether or not run is high.
- Prescaler: when run=1, it increments each cycle. At the cycle where the value is TICKS_PER_SEC-1, it wraps to 0 and an internal sec_tick is asserted. When run=0, the prescaler holds.
- Tick latency: tick_1hz is 1 in the cycle after sec_tick, together with the updated digits. The first tick_1hz after reset with run=1 appears TICKS_PER_SEC cycles after reset deasserts.
- Digit update on sec_tick:
  - bcd < 9: bcd + 1.
  - bcd == 9 and bcd_10s < 5: bcd = 0, bcd_10s + 1.
  - bcd == 9 and bcd_10s == 5: both digits = 0, min_tick = 1 for exactly one cycle, coincident with tick_1hz.
- tick_1hz and min_tick are 0 in every cycle not described above.
- bcd_10s changes only on a tens carry, wrap, clear, load, or reset. It is never transiently 0 outside those events.
- Digits never leave 0..9 / 0..5. Encodings >9 units or >5 tens are unreachable. If forced (for example, by X-propagation repair), the next sec_tick sets both digits to 00 without asserting min_tick.
- Simultaneous clear and sec_tick: clear wins; no pulses are emitted.

Optional Feature:
- Macro: BCD_SEC_LOAD_EN.
- Defined:
  - load=1 with a valid load_val (units <= 9, tens <= 5): digits = load_val and prescaler = 0. No tick_1hz or min_tick pulse is emitted that cycle.
  - load=1 with an invalid load_val: the load is ignored, and counting proceeds normally that cycle.
- Undefined: load and load_val remain as ports but are ignored. There is no preset logic.

Test Plan:
- TICKS_PER_SEC=4, reset 3 cycles, then run=1 -> tick_1hz is high at cycles 4, 8, 12 after reset release; bcd goes 1, 2, 3; bcd_10s = 0.
- Run 60 ticks from 00 -> bcd/bcd_10s go 09 -> 10 at tick 10. At tick 60 both = 0, and min_tick and tick_1hz are high in the same single cycle. A minute counter model attached to bcd_10s increments exactly once.
- run=0 for 10 cycles at prescaler = 2, then run=1 -> the next tick arrives 2 cycles after resume; digits are unchanged while paused.
- clear asserted in the same cycle as a 59->00 sec_tick -> digits 00, tick_1hz = 0, min_tick = 0; the prescaler restarts from 0.
- Reset asserted at digits 37 mid-prescale -> next edge shows all outputs 0; counting resumes from 00.
- With BCD_SEC_LOAD_EN: load_val = 0x58 -> digits 58; after 2 ticks -> 00 with min_tick pulse. load_val = 0x6A -> ignored. Without the macro: load = 1 has no effect.
